// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: types and constants shared by the AHB-to-APB bridge blocks
// (the controller FSM and the AHB slave-side decode).
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WWAIT  = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } apb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Three 64 MB peripheral windows; PERIPH_LIMIT closes the last one.
  localparam logic [31:0] PERIPH0_BASE = 32'h8000_0000;
  localparam logic [31:0] PERIPH1_BASE = 32'h8400_0000;
  localparam logic [31:0] PERIPH2_BASE = 32'h8800_0000;
  localparam logic [31:0] PERIPH_LIMIT = 32'h8C00_0000;

  // Wide enough for TIMEOUT up to 255.
  localparam int WCNT_W = 8;

  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  function automatic logic [2:0] periph_sel(input logic [31:0] addr);
    if (addr >= PERIPH0_BASE && addr < PERIPH1_BASE) return 3'b001;
    if (addr >= PERIPH1_BASE && addr < PERIPH2_BASE) return 3'b010;
    if (addr >= PERIPH2_BASE && addr < PERIPH_LIMIT) return 3'b100;
    return 3'b000;
  endfunction

endpackage

// File: rtl/apb_controller_if.sv
// apb_controller_if: AHB-side request, APB bus and response signals of the
// bridge controller. master = controller side, slave = environment side.
interface apb_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // AHB request (address + data phase)
  logic              valid;
  logic [ADDR_W-1:0] Haddr;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic [2:0]        tempselx;
  // APB completer response
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  // APB requester outputs
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  // AHB response
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic              timeout_err;

  modport master (
    input  valid, Haddr, Hwrite, Hwdata, tempselx, Prdata, Pready,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata, timeout_err
  );

  modport slave (
    output valid, Haddr, Hwrite, Hwdata, tempselx, Prdata, Pready,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata, timeout_err
  );
endinterface

// File: rtl/apb_controller.sv
// apb_controller: turns one accepted AHB transfer into one APB transfer,
// stalling AHB via Hreadyout and aborting if Pready stays low too long.
module apb_controller
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_controller_if.master bus
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_q, hready_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              err_q, err_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]        sel_lo;

  // Keep only the lowest set bit so a malformed multi-hot select can never
  // drive more than one peripheral.
  assign sel_lo = bus.tempselx & (~bus.tempselx + 3'd1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    hready_d = hready_q;
    hrdata_d = hrdata_q;
    err_d    = 1'b0;
    wcnt_d   = wcnt_q;

    unique case (state_q)
      IDLE: begin
        hready_d = 1'b1;
        psel_d   = 3'b000;
        pen_d    = 1'b0;
        if (bus.valid && (bus.tempselx != 3'b000)) begin
          paddr_d  = bus.Haddr;
          pwrite_d = bus.Hwrite;
          sel_d    = sel_lo;
          hready_d = 1'b0;
          if (bus.Hwrite) begin
            state_d = WWAIT;
          end else begin
            // Reads skip the data-phase wait, so select goes out right away.
            psel_d  = sel_lo;
            wcnt_d  = '0;
            state_d = SETUP;
          end
        end
      end

      WWAIT: begin
        pwdata_d = bus.Hwdata;
        psel_d   = sel_q;
        wcnt_d   = '0;
        state_d  = SETUP;
      end

      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end

      ACCESS: begin
        if (bus.Pready) begin
          psel_d   = 3'b000;
          pen_d    = 1'b0;
          hready_d = 1'b1;
          if (!pwrite_q) hrdata_d = bus.Prdata;
          state_d  = IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          // Abort: release the bus and the master, keep old read data.
          psel_d   = 3'b000;
          pen_d    = 1'b0;
          hready_d = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      psel_q   <= '0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      hready_q <= 1'b1;
      hrdata_q <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      hready_q <= hready_d;
      hrdata_q <= hrdata_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.Pselx       = psel_q;
  assign bus.Penable     = pen_q;
  assign bus.Pwrite      = pwrite_q;
  assign bus.Paddr       = paddr_q;
  assign bus.Pwdata      = pwdata_q;
  assign bus.Hreadyout   = hready_q;
  assign bus.Hrdata      = hrdata_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller: scoreboard bench; issue() pushes the expected APB
// transfer, the monitor pops it when the DUT completes or aborts it.
module tb_apb_controller;
  import ahb2apb_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  logic Hclk;
  logic Hreset;
  apb_controller_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  int          want_wait = 0;
  logic [31:0] last_rd = '0;

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Drive an AHB transfer now (away from the edge); data phase follows.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int nwait);
    exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.to = (nwait >= TO);
    sb.push_back(e);
    want_wait    = nwait;
    bus.Prdata   = rdata;
    bus.valid    = 1'b1;
    bus.Haddr    = addr;
    bus.Hwrite   = wr;
    bus.tempselx = periph_sel(addr);
    @(posedge Hclk); #1;
    bus.valid    = 1'b0;
    bus.Hwdata   = wdata;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge Hclk);
      n++;
    end while (!bus.Hreadyout && n < budget);
    chk("done_in_budget", bus.Hreadyout, 1);
  endtask

  // APB completer: hold Pready low for want_wait ACCESS cycles.
  initial begin
    int acc = 0;
    bus.Pready = 1'b0;
    forever begin
      @(posedge Hclk); #1;
      if (bus.Penable) begin
        if (acc < want_wait) begin
          bus.Pready = 1'b0;
          acc++;
        end else begin
          bus.Pready = 1'b1;
        end
      end else begin
        acc = 0;
        bus.Pready = 1'b0;
      end
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    exp_t pe;
    bit   pend = 0;
    forever begin
      @(negedge Hclk);
      if (Hreset) begin
        pend = 0;
        continue;
      end
      chk("pselx_onehot0", $onehot0(bus.Pselx), 1);
      chk("penable_needs_psel", (!bus.Penable) || (bus.Pselx != 3'b000), 1);
      if (pend) begin
        chk("hready_after_done", bus.Hreadyout, 1);
        chk("hrdata", bus.Hrdata, last_rd);
        chk("no_timeout_err", bus.timeout_err, 0);
        pend = 0;
      end
      if (bus.Penable && bus.Pready) begin
        if (sb.size() == 0) begin
          chk("sb_has_entry", 0, 1);
        end else begin
          pe = sb.pop_front();
          chk("paddr", bus.Paddr, pe.addr);
          chk("pwrite", bus.Pwrite, pe.wr);
          chk("pselx", bus.Pselx, periph_sel(pe.addr));
          if (pe.wr) chk("pwdata", bus.Pwdata, pe.wdata);
          else last_rd = pe.rdata;
          chk("expect_no_abort", pe.to, 0);
          pend = 1;
        end
      end else if (bus.timeout_err) begin
        if (sb.size() == 0) begin
          chk("sb_has_entry_to", 0, 1);
        end else begin
          pe = sb.pop_front();
          chk("expect_abort", pe.to, 1);
          chk("to_hready", bus.Hreadyout, 1);
          chk("to_hrdata_kept", bus.Hrdata, last_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    Hreset       = 1'b1;
    bus.valid    = 1'b0;
    bus.Haddr    = '0;
    bus.Hwrite   = 1'b0;
    bus.Hwdata   = '0;
    bus.tempselx = '0;
    bus.Prdata   = '0;
    repeat (2) @(negedge Hclk);
    chk("rst_hready", bus.Hreadyout, 1);
    chk("rst_pselx", bus.Pselx, 0);
    chk("rst_penable", bus.Penable, 0);
    chk("rst_pwrite", bus.Pwrite, 0);
    chk("rst_paddr", bus.Paddr, 0);
    chk("rst_pwdata", bus.Pwdata, 0);
    chk("rst_hrdata", bus.Hrdata, 0);
    chk("rst_err", bus.timeout_err, 0);
    #2 Hreset = 1'b0;

    // Read, sampled on the first edge after reset release.
    issue(1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    @(negedge Hclk);
    chk("rd_c1_pselx", bus.Pselx, 3'b001);
    chk("rd_c1_penable", bus.Penable, 0);
    chk("rd_c1_hready", bus.Hreadyout, 0);
    @(negedge Hclk);
    chk("rd_c2_pselx", bus.Pselx, 3'b001);
    chk("rd_c2_penable", bus.Penable, 1);
    @(negedge Hclk);
    chk("rd_c3_hready", bus.Hreadyout, 1);
    chk("rd_c3_hrdata", bus.Hrdata, 32'hDEAD_BEEF);
    chk("rd_c3_pselx", bus.Pselx, 0);

    // valid with no peripheral select is ignored.
    bus.valid = 1'b1; bus.tempselx = 3'b000; bus.Haddr = 32'h9000_0000;
    @(posedge Hclk); #1 bus.valid = 1'b0;
    @(negedge Hclk);
    chk("nosel_hready", bus.Hreadyout, 1);
    chk("nosel_pselx", bus.Pselx, 0);
    chk("nosel_paddr_held", bus.Paddr, 32'h8000_0010);

    // Write timing.
    issue(1'b1, 32'h8400_0004, 32'h1234_5678, 32'h0, 0);
    @(negedge Hclk);
    chk("wr_c1_pselx", bus.Pselx, 0);
    chk("wr_c1_hready", bus.Hreadyout, 0);
    @(negedge Hclk);
    chk("wr_c2_pselx", bus.Pselx, 3'b010);
    chk("wr_c2_penable", bus.Penable, 0);
    chk("wr_c2_pwdata", bus.Pwdata, 32'h1234_5678);
    chk("wr_c2_pwrite", bus.Pwrite, 1);
    chk("wr_c2_paddr", bus.Paddr, 32'h8400_0004);
    @(negedge Hclk);
    chk("wr_c3_penable", bus.Penable, 1);
    chk("wr_c3_hready", bus.Hreadyout, 0);
    @(negedge Hclk);
    chk("wr_c4_hready", bus.Hreadyout, 1);
    chk("wr_c4_hrdata_kept", bus.Hrdata, 32'hDEAD_BEEF);

    // Read with three wait states.
    issue(1'b0, 32'h8800_0000, 32'h0, 32'hCAFE_0001, 3);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Hclk);
      if (bus.Penable) begin
        acc++;
        chk("ws_pselx_stable", bus.Pselx, 3'b100);
        chk("ws_paddr_stable", bus.Paddr, 32'h8800_0000);
        chk("ws_pwrite_stable", bus.Pwrite, 0);
      end
      if (bus.Hreadyout) break;
    end
    chk("ws_access_cycles", acc, 4);
    chk("ws_no_err", bus.timeout_err, 0);
    chk("ws_hrdata", bus.Hrdata, 32'hCAFE_0001);

    // Pready never rises: abort after TIMEOUT ACCESS cycles.
    issue(1'b0, 32'h8800_0040, 32'h0, 32'hBAD0_BAD0, 255);
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Hclk);
      if (bus.Penable) acc++;
      if (bus.Hreadyout) break;
    end
    chk("to_access_cycles", acc, TO);
    chk("to_err_pulse", bus.timeout_err, 1);
    chk("to_hrdata_unchanged", bus.Hrdata, 32'hCAFE_0001);
    @(negedge Hclk);
    chk("to_err_once", bus.timeout_err, 0);
    chk("to_idle_pselx", bus.Pselx, 0);

    // Reset in the ACCESS phase of a write.
    issue(1'b1, 32'h8400_0008, 32'hA5A5_5A5A, 32'h0, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge Hclk);
      if (bus.Penable) break;
    end
    chk("rst_mid_in_access", bus.Penable, 1);
    #2 Hreset = 1'b1;
    #1;
    chk("rst_mid_pselx", bus.Pselx, 0);
    chk("rst_mid_penable", bus.Penable, 0);
    chk("rst_mid_hready", bus.Hreadyout, 1);
    chk("rst_mid_err", bus.timeout_err, 0);
    void'(sb.pop_front());
    last_rd = '0;
    want_wait = 0;
    @(negedge Hclk);
    chk("rst_mid_no_err_later", bus.timeout_err, 0);
    #2 Hreset = 1'b0;
    issue(1'b0, 32'h8000_0100, 32'h0, 32'h0F0F_1234, 1);
    wait_done(20);

    // Back-to-back: read then write issued in the Hreadyout cycle.
    issue(1'b0, 32'h8000_0020, 32'h0, 32'h1111_0000, 0);
    wait_done(20);
    issue(1'b1, 32'h8400_0030, 32'h2222_3333, 32'h0, 0);
    @(negedge Hclk);
    chk("b2b_second_started", bus.Hreadyout, 0);
    wait_done(20);

    // Random traffic, one forced abort in the middle.
    for (int i = 0; i < 12; i++) begin
      logic        wr;
      logic [31:0] addr;
      int          nw;
      wr   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       addr = PERIPH0_BASE;
        1:       addr = PERIPH1_BASE;
        default: addr = PERIPH2_BASE;
      endcase
      addr = addr + ($urandom_range(0, 255) << 2);
      nw   = (i == 5) ? 20 : int'($urandom_range(0, 3));
      issue(wr, addr, $urandom, $urandom, nw);
      wait_done(60);
    end

    repeat (2) @(negedge Hclk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
